game_tick_clock: RTL and testbench

- Tick-clock generator for the RPG engine.
- Derives the engine step clock from the system clock by programmable division with a 50% duty cycle.
- Also emits a single-cycle tick pulse at each rising edge of the step clock. The engine samples new commands and redraws on that tick.
- Sits at the top level and feeds the command/map engine and its display logic.

---
 rtl/game_pkg.sv | 28 ++
 rtl/game_tick_clock.sv | 75 +++++++
 tb/tb_game_tick_clock.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared constants for the RPG engine.
//   - DefaultCntW: default width of the tick-clock divider counter.
//   - tile_e:      tile IDs stored in the map memory.
//   - MapW/MapH/MapCells: map geometry.
package game_pkg;

    localparam int unsigned DefaultCntW = 16;

    typedef enum logic [2:0] {
        TileUnknown  = 3'd0,
        TileCurrent  = 3'd1,
        TileEntrance = 3'd2,
        TileExit     = 3'd3,
        TileBlank    = 3'd4,
        TileWall     = 3'd5,
        TileEnemy    = 3'd6
    } tile_e;

    localparam int unsigned MapW     = 20;
    localparam int unsigned MapH     = 20;
    localparam int unsigned MapCells = MapW * MapH;

    // Tiles the player may step onto.
    function automatic logic is_walkable(input tile_e tile);
        return (tile == TileBlank) || (tile == TileEntrance) || (tile == TileExit);
    endfunction

endpackage

// File: rtl/game_tick_clock.sv
// Tick-clock generator: divides clk into a 50% duty step clock and emits a one-cycle
// tick in the cycle the step clock rises.
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   enable_i      run enable; low parks clk_o low and clears the counter
//   half_period_i requested half-period in clk cycles; 0 selects DEFAULT_HALF
//   clk_o         divided step clock (registered)
//   tick_o        one-cycle pulse coincident with clk_o rising (registered)
//   count_o       current divider count
module game_tick_clock
    import game_pkg::*;
#(
    parameter int unsigned            CNT_W        = DefaultCntW,
    parameter logic [CNT_W-1:0]       DEFAULT_HALF = CNT_W'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] half_period_i,
    output logic             clk_o,
    output logic             tick_o,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] half_sel;
    logic             wrap;

    // A zero request falls back to the default so the shadow is never 0.
    assign half_sel = (half_period_i == '0) ? DEFAULT_HALF : half_period_i;
    assign wrap     = (count_q == (shadow_q - CNT_W'(1)));

    always_comb begin
        shadow_d = shadow_q;
        count_d  = count_q;
        clk_d    = clk_q;
        tick_d   = 1'b0;
        if (!enable_i) begin
            count_d  = '0;
            clk_d    = 1'b0;
            shadow_d = half_sel;
        end else if (wrap) begin
            // Reload only at the phase boundary so a running phase keeps its length.
            count_d  = '0;
            clk_d    = ~clk_q;
            tick_d   = ~clk_q;
            shadow_d = half_sel;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= DEFAULT_HALF;
            count_q  <= '0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            count_q  <= count_d;
            clk_q    <= clk_d;
            tick_q   <= tick_d;
        end
    end

    assign clk_o   = clk_q;
    assign tick_o  = tick_q;
    assign count_o = count_q;

endmodule

// File: tb/tb_game_tick_clock.sv
// Directed bench for game_tick_clock. The DUT is built with a 12-bit counter so the
// maximum-half-period case (2^12-1) runs in a few tens of thousands of cycles.
module tb_game_tick_clock;

    localparam int unsigned CNT_W = 12;
    localparam logic [CNT_W-1:0] MAX_HALF = 12'hFFF;

    logic             clk;
    logic             rst;
    logic             enable_i;
    logic [CNT_W-1:0] half_period_i;
    logic             clk_o;
    logic             tick_o;
    logic [CNT_W-1:0] count_o;

    int total;
    int bad;
    int ticks;
    int maxc;

    game_tick_clock #(
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (12'd1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable_i      (enable_i),
        .half_period_i (half_period_i),
        .clk_o         (clk_o),
        .tick_o        (tick_o),
        .count_o       (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input int c, input int t, input int k);
        check({tag, ".clk"}, int'(clk_o), c);
        check({tag, ".tick"}, int'(tick_o), t);
        check({tag, ".count"}, int'(count_o), k);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Reset dominates enable=1
        rst = 1'b1; enable_i = 1'b1; half_period_i = '0;
        step(1); chk("rst0", 0, 0, 0);
        step(1); chk("rst1", 0, 0, 0);

        // Default half=1: toggle every cycle, tick every other cycle
        rst = 1'b0;
        step(1); chk("def_r1", 1, 1, 0);
        step(1); chk("def_f1", 0, 0, 0);
        step(1); chk("def_r2", 1, 1, 0);
        step(1); chk("def_f2", 0, 0, 0);

        // half=3: one disabled cycle loads the shadow, then 3/3 phases
        enable_i = 1'b0; half_period_i = 12'd3;
        step(1); chk("h3_dis", 0, 0, 0);
        enable_i = 1'b1;
        step(1); chk("h3_c1", 0, 0, 1);
        step(1); chk("h3_c2", 0, 0, 2);
        step(1); chk("h3_rise", 1, 1, 0);
        step(1); chk("h3_hi1", 1, 0, 1);
        step(1); chk("h3_hi2", 1, 0, 2);
        step(1); chk("h3_fall", 0, 0, 0);
        step(2); chk("h3_lo2", 0, 0, 2);
        step(1); chk("h3_rise2", 1, 1, 0);

        // half 3->5 at count=1: high phase still lasts 3, then 5-cycle phases
        step(1); chk("h35_c1", 1, 0, 1);
        half_period_i = 12'd5;
        step(1); chk("h35_c2", 1, 0, 2);
        step(1); chk("h35_fall", 0, 0, 0);
        step(4); chk("h35_lo4", 0, 0, 4);
        step(1); chk("h35_rise", 1, 1, 0);
        step(4); chk("h35_hi4", 1, 0, 4);
        step(1); chk("h35_fall2", 0, 0, 0);

        // Drop enable while high, re-enable with half=4
        step(5); chk("en_rise", 1, 1, 0);
        step(1); chk("en_hi1", 1, 0, 1);
        enable_i = 1'b0; half_period_i = 12'd4;
        step(1); chk("en_off", 0, 0, 0);
        enable_i = 1'b1;
        step(3); chk("en_c3", 0, 0, 3);
        step(1); chk("en_rise4", 1, 1, 0);

        // Reset mid high phase with half=5; shadow returns to default 1
        half_period_i = 12'd5;
        step(3); chk("r5_c3", 1, 0, 3);
        step(1); chk("r5_fall", 0, 0, 0);
        step(5); chk("r5_rise", 1, 1, 0);
        step(2); chk("r5_hi2", 1, 0, 2);
        rst = 1'b1;
        step(1); chk("r5_rst", 0, 0, 0);
        rst = 1'b0; half_period_i = 12'd7;
        // Shadow is DEFAULT_HALF=1, so the first edge toggles; it then loads 7
        step(1); chk("r5_def", 1, 1, 0);
        step(1); chk("r5_h7", 1, 0, 1);

        // Maximum half period for two full periods
        enable_i = 1'b0; half_period_i = MAX_HALF;
        step(1); chk("max_dis", 0, 0, 0);
        enable_i = 1'b1;
        step(4094); chk("max_top", 0, 0, 4094);
        step(1); chk("max_rise0", 1, 1, 0);
        for (int p = 0; p < 2; p++) begin
            ticks = 0;
            maxc  = 0;
            for (int i = 0; i < 8190; i++) begin
                step(1);
                ticks += int'(tick_o);
                if (int'(count_o) > maxc) maxc = int'(count_o);
                if (i == 4094) chk("max_fall", 0, 0, 0);
            end
            chk("max_rise", 1, 1, 0);
            check("max_ticks", ticks, 1);
            check("max_cnt", maxc, 4094);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
